// File: rtl/req_encoder_pkg.sv
// Shared constants and helpers for the request-to-index encoder.
// Holds the default index width, a ceil-log2 helper and the default index type.
package req_encoder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 7;

    // Number of bits needed to hold values 0 .. value-1 (minimum 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((32'd1 << bits) < value) begin
            bits = bits + 1;
        end
        return (bits == 0) ? 1 : bits;
    endfunction

    localparam int unsigned IDX_W = DEFAULT_WIDTH;

    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/prio_find_first.sv
// Combinational find-first-set over LINES bits, searching upward from i_start
// and wrapping past LINES-1 to 0; reports the wrapped index and a found flag.
module prio_find_first
    import req_encoder_pkg::*;
#(
    parameter int unsigned LINES = 8,
    parameter int unsigned IW    = clog2(LINES)
) (
    input  logic [LINES-1:0] i_vec,
    input  logic [IW-1:0]    i_start,
    output logic [IW-1:0]    o_idx,
    output logic             o_found
);

    logic [2*LINES-1:0] w_dbl;
    logic [2*LINES-1:0] w_mask;
    logic [2*LINES-1:0] w_masked;
    logic [IW:0]        w_pos;

    // Two copies side by side: masking off bits below i_start in the lower copy
    // turns a wrapping search into a plain lowest-set-bit search.
    assign w_dbl    = {i_vec, i_vec};
    assign w_mask   = {(2*LINES){1'b1}} << i_start;
    assign w_masked = w_dbl & w_mask;

    always_comb begin
        w_pos   = '0;
        o_found = 1'b0;
        for (int unsigned j = 0; j < 2*LINES; j++) begin
            if (w_masked[j] && !o_found) begin
                o_found = 1'b1;
                w_pos   = (IW+1)'(j);
            end
        end
    end

    assign o_idx = IW'((w_pos >= (IW+1)'(LINES)) ? (w_pos - (IW+1)'(LINES)) : w_pos);

endmodule

// File: rtl/req_encoder.sv
// Latches pulse requests per line and emits one binary index per accepted transfer.
// Define REQ_ENCODER_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module req_encoder
    import req_encoder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LINES = 2**WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LINES-1:0] req,
    output logic [WIDTH-1:0] out_idx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    logic [LINES-1:0] r_pending;
    logic [WIDTH-1:0] r_out_idx;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_overrun;

    logic             w_load;
    logic             w_found;
    logic             w_grant;
    logic [WIDTH-1:0] w_winner;
    logic [WIDTH-1:0] w_start;
    logic [LINES-1:0] w_clr;

    assign w_load  = ~r_out_valid | out_ready;
    assign w_grant = w_load & w_found;
    assign w_clr   = w_grant ? (LINES'(1) << w_winner) : '0;

`ifdef REQ_ENCODER_RR_EN
    logic [WIDTH-1:0] r_ptr;

    assign w_start = r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_winner == WIDTH'(LINES-1)) ? '0 : w_winner + 1'b1;
        end
    end
`else
    assign w_start = '0;
`endif

    prio_find_first #(
        .LINES (LINES),
        .IW    (WIDTH)
    ) u_find (
        .i_vec   (r_pending),
        .i_start (w_start),
        .o_idx   (w_winner),
        .o_found (w_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= '0;
            r_out_idx   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // A new request on the line being granted this edge re-arms it.
            r_pending <= (r_pending & ~w_clr) | req;
            r_overrun <= |(req & r_pending & ~w_clr);
            r_busy    <= (|r_pending) | r_out_valid;
            if (w_load) begin
                r_out_valid <= w_found;
                if (w_found) begin
                    r_out_idx <= w_winner;
                end
            end
        end
    end

    assign out_idx   = r_out_idx;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_req_encoder.sv
// Self-checking bench for req_encoder (WIDTH=3, LINES=8): directed scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_req_encoder;

`ifdef REQ_ENCODER_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] req = '0;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    bit m_pend [8];
    int m_ptr;
    bit m_valid;
    int m_idx;
    bit m_busy;
    bit m_ovr;

    always #5 clk = ~clk;

    req_encoder #(
        .WIDTH (3),
        .LINES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One rising edge of the reference: grant from pending, then merge new requests.
    task automatic model_edge(input logic [7:0] r, input bit rdy, input bit rs);
        int  clr;
        int  win;
        int  base;
        bit  any;
        bit  old_valid;
        if (rs) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
            m_ptr = 0; m_valid = 1'b0; m_idx = 0; m_busy = 1'b0; m_ovr = 1'b0;
            return;
        end
        clr = -1;
        any = 1'b0;
        old_valid = m_valid;
        for (int i = 0; i < 8; i++) any |= m_pend[i];
        if (!m_valid || rdy) begin
            base = RR ? m_ptr : 0;
            win  = -1;
            for (int k = 0; k < 8; k++) begin
                int c;
                c = (base + k) % 8;
                if (win < 0 && m_pend[c]) win = c;
            end
            if (win >= 0) begin
                m_idx = win; m_valid = 1'b1; clr = win; m_ptr = (win + 1) % 8;
            end else begin
                m_valid = 1'b0;
            end
        end
        m_ovr = 1'b0;
        for (int i = 0; i < 8; i++) if (r[i] && m_pend[i] && i != clr) m_ovr = 1'b1;
        m_busy = any || old_valid;
        for (int i = 0; i < 8; i++) m_pend[i] = (m_pend[i] && i != clr) || r[i];
    endtask

    task automatic cyc(input logic [7:0] r, input bit rdy);
        req = r;
        out_ready = rdy;
        @(posedge clk);
        model_edge(r, rdy, rst);
        @(negedge clk);
        check_eq("out_valid", 32'(out_valid), 32'(m_valid));
        check_eq("out_idx", 32'(out_idx), 32'(m_idx));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(8'h00, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] r;
        bit         rdy;
        int         ovr_cnt;
        int         grant3;

        rst = 1'b1;
        cyc(8'hFF, 1'b1);
        rst = 1'b0;
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_idx", 32'(out_idx), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ovr", 32'(overrun), 32'd0);

        // Single request, latency of two edges.
        cyc(8'h20, 1'b1);
        check_eq("lat_edge1", 32'(out_valid), 32'd0);
        cyc(8'h00, 1'b1);
        check_eq("single_valid", 32'(out_valid), 32'd1);
        check_eq("single_idx", 32'(out_idx), 32'd5);
        cyc(8'h00, 1'b1);
        check_eq("single_drop", 32'(out_valid), 32'd0);
        check_eq("busy_lag", 32'(busy), 32'd1);
        cyc(8'h00, 1'b1);
        check_eq("busy_fall", 32'(busy), 32'd0);

        // Three simultaneous requests drain on consecutive cycles.
        do_reset();
        cyc(8'hA4, 1'b1);
        cyc(8'h00, 1'b1);
        check_eq("a4_first", 32'(out_idx), 32'd2);
        cyc(8'h00, 1'b1);
        check_eq("a4_second", 32'(out_idx), 32'd5);
        cyc(8'h00, 1'b1);
        check_eq("a4_third", 32'(out_idx), 32'd7);
        check_eq("a4_valid", 32'(out_valid), 32'd1);
        cyc(8'h00, 1'b1);
        check_eq("a4_empty", 32'(out_valid), 32'd0);

        // Back-pressure holds the grant while the other line stays pending.
        do_reset();
        cyc(8'h0C, 1'b0);
        cyc(8'h00, 1'b0);
        check_eq("bp_idx", 32'(out_idx), 32'd2);
        cyc(8'h00, 1'b0);
        check_eq("bp_hold_idx", 32'(out_idx), 32'd2);
        check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
        cyc(8'h00, 1'b1);
        check_eq("bp_next", 32'(out_idx), 32'd3);
        cyc(8'h00, 1'b1);
        check_eq("bp_done", 32'(out_valid), 32'd0);

        // Pointer sits past 5; both arbitration modes give 0 then 5 here.
        do_reset();
        cyc(8'h20, 1'b1);
        cyc(8'h00, 1'b1);
        for (int rep = 0; rep < 2; rep++) begin
            cyc(8'h21, 1'b1);
            cyc(8'h00, 1'b1);
            check_eq("wrap_first", 32'(out_idx), 32'd0);
            cyc(8'h00, 1'b1);
            check_eq("wrap_second", 32'(out_idx), 32'd5);
        end

        // Duplicate request while pending merges and flags overrun once.
        do_reset();
        cyc(8'h01, 1'b0);
        cyc(8'h00, 1'b0);
        ovr_cnt = 0;
        cyc(8'h08, 1'b0); ovr_cnt += int'(overrun);
        cyc(8'h00, 1'b0); ovr_cnt += int'(overrun);
        cyc(8'h08, 1'b0); ovr_cnt += int'(overrun);
        cyc(8'h00, 1'b0); ovr_cnt += int'(overrun);
        grant3 = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(8'h00, 1'b1);
            if (out_valid && out_idx == 3'd3) grant3++;
        end
        check_eq("ovr_pulses", 32'(ovr_cnt), 32'd1);
        check_eq("ovr_grants", 32'(grant3), 32'd1);

        // Reset with every line pending and an unaccepted grant.
        cyc(8'hFF, 1'b0);
        cyc(8'h00, 1'b0);
        check_eq("full_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        cyc(8'hFF, 1'b1);
        rst = 1'b0;
        check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_idx", 32'(out_idx), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(8'h00, 1'b1);
            check_eq("mid_rst_nogrant", 32'(out_valid), 32'd0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 500; i++) begin
            r   = 8'($urandom) & 8'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cyc(r, rdy);
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
